// File: rtl/axis_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_pkt
// Description : AXI4-Stream FWFT FIFO with occupancy flags and optional
//               whole-packet release.
// Revision    : 1.0  initial release
// ============================================================================
module axis_fifo_pkt #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 5,
   parameter int PACKET_MODE  = 0,
   parameter int AFULL_LEVEL  = 2**DEPTH - 2,
   parameter int AEMPTY_LEVEL = 1
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic [WIDTH-1:0] s_axis_tdata,
   input  logic             s_axis_tlast,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [WIDTH-1:0] m_axis_tdata,
   output logic             m_axis_tlast,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [DEPTH:0]   count,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int             C_NENT   = 2**DEPTH;
   localparam logic [DEPTH:0] C_FULL   = {1'b1, {DEPTH{1'b0}}};
   localparam logic [DEPTH:0] C_AFULL  = AFULL_LEVEL[DEPTH:0];
   localparam logic [DEPTH:0] C_AEMPTY = AEMPTY_LEVEL[DEPTH:0];

   logic [WIDTH:0]   r_mem [C_NENT];
   logic [DEPTH-1:0] r_wr_ptr;
   logic [DEPTH-1:0] r_rd_ptr;
   logic [DEPTH:0]   r_count;
   logic             w_push;
   logic             w_pop;
   logic             w_release;

   // Input side never looks at the consumer, so a full FIFO refuses even on a pop cycle.
   assign s_axis_tready = ~areset & (r_count != C_FULL);
   assign w_push        = s_axis_tvalid & s_axis_tready;
   assign m_axis_tvalid = (r_count != '0) & w_release;
   assign w_pop         = m_axis_tvalid & m_axis_tready;

   assign {m_axis_tlast, m_axis_tdata} = r_mem[r_rd_ptr];

   assign count        = r_count;
   assign almost_full  = (r_count >= C_AFULL);
   assign almost_empty = (r_count <= C_AEMPTY);

   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + DEPTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + DEPTH'(1);
         end
         if (w_push & ~w_pop) begin
            r_count <= r_count + (DEPTH+1)'(1);
         end else if (~w_push & w_pop) begin
            r_count <= r_count - (DEPTH+1)'(1);
         end
      end
   end

   generate
      if (PACKET_MODE != 0) begin : g_pkt
         logic [DEPTH:0] r_pkts;
         logic           w_in_last;
         logic           w_out_last;

         assign w_in_last  = w_push & s_axis_tlast;
         assign w_out_last = w_pop & m_axis_tlast;

         always_ff @(posedge aclk) begin
            if (areset) begin
               r_pkts <= '0;
            end else if (w_in_last & ~w_out_last) begin
               r_pkts <= r_pkts + (DEPTH+1)'(1);
            end else if (~w_in_last & w_out_last) begin
               r_pkts <= r_pkts - (DEPTH+1)'(1);
            end
         end

         // A full FIFO with no complete packet must stream anyway, or an oversize packet deadlocks.
         assign w_release = (r_pkts != '0) | (r_count == C_FULL);
      end else begin : g_nopkt
         assign w_release = 1'b1;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_fifo_pkt
// Description : Directed self-checking bench for axis_fifo_pkt (three configs).
// Revision    : 1.0  initial release
// ============================================================================
module tb_axis_fifo_pkt;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: mode 0, DEPTH=2
   logic [7:0] a_tdata, a_mdata;
   logic       a_tlast, a_tvalid, a_tready, a_mlast, a_mvalid, a_mready, a_af, a_ae;
   logic [2:0] a_count;
   // Instance B: mode 1, DEPTH=3
   logic [7:0] b_tdata, b_mdata;
   logic       b_tlast, b_tvalid, b_tready, b_mlast, b_mvalid, b_mready, b_af, b_ae;
   logic [3:0] b_count;
   // Instance C: mode 1, DEPTH=2
   logic [7:0] c_tdata, c_mdata;
   logic       c_tlast, c_tvalid, c_tready, c_mlast, c_mvalid, c_mready, c_af, c_ae;
   logic [2:0] c_count;

   axis_fifo_pkt #(.WIDTH(8), .DEPTH(2), .PACKET_MODE(0)) u_a (
      .aclk(clk), .areset(rst),
      .s_axis_tdata(a_tdata), .s_axis_tlast(a_tlast), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
      .m_axis_tdata(a_mdata), .m_axis_tlast(a_mlast), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
      .count(a_count), .almost_full(a_af), .almost_empty(a_ae));

   axis_fifo_pkt #(.WIDTH(8), .DEPTH(3), .PACKET_MODE(1)) u_b (
      .aclk(clk), .areset(rst),
      .s_axis_tdata(b_tdata), .s_axis_tlast(b_tlast), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
      .m_axis_tdata(b_mdata), .m_axis_tlast(b_mlast), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
      .count(b_count), .almost_full(b_af), .almost_empty(b_ae));

   axis_fifo_pkt #(.WIDTH(8), .DEPTH(2), .PACKET_MODE(1)) u_c (
      .aclk(clk), .areset(rst),
      .s_axis_tdata(c_tdata), .s_axis_tlast(c_tlast), .s_axis_tvalid(c_tvalid), .s_axis_tready(c_tready),
      .m_axis_tdata(c_mdata), .m_axis_tlast(c_mlast), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready),
      .count(c_count), .almost_full(c_af), .almost_empty(c_ae));

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [8:0] q_a[$];
   logic [7:0] a_next = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Cycle loop on instance A with a queue model; percentages set valid/ready density.
   task automatic run_a(input int ncyc, input int vpct, input int rpct);
      logic push, pop;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         check_eq("a_count",  32'(a_count),  32'(q_a.size()));
         check_eq("a_mvalid", 32'(a_mvalid), 32'(q_a.size() != 0));
         check_eq("a_tready", 32'(a_tready), 32'(q_a.size() != 4));
         check_eq("a_afull",  32'(a_af),     32'(q_a.size() >= 2));
         check_eq("a_aempty", 32'(a_ae),     32'(q_a.size() <= 1));
         a_tvalid = (int'($urandom_range(99)) < vpct);
         a_tdata  = a_next;
         a_tlast  = a_next[0];
         a_mready = (int'($urandom_range(99)) < rpct);
         push = a_tvalid & a_tready;
         pop  = a_mvalid & a_mready;
         if (pop && q_a.size() != 0) check_eq("a_data", 32'({a_mlast, a_mdata}), 32'(q_a[0]));
         @(posedge clk);
         if (pop && q_a.size() != 0) void'(q_a.pop_front());
         if (push) begin
            q_a.push_back({a_tlast, a_tdata});
            a_next = a_next + 8'd1;
         end
      end
   endtask

   initial begin
      int pops;
      int pushed;
      logic [7:0] c_exp;
      rst = 1'b1;
      a_tdata = '0; a_tlast = 0; a_tvalid = 0; a_mready = 0;
      b_tdata = '0; b_tlast = 0; b_tvalid = 0; b_mready = 0;
      c_tdata = '0; c_tlast = 0; c_tvalid = 0; c_mready = 0;
      repeat (2) @(posedge clk);

      // Reset state
      @(negedge clk);
      check_eq("rst_tready", 32'(a_tready), 32'd0);
      check_eq("rst_mvalid", 32'(a_mvalid), 32'd0);
      check_eq("rst_count",  32'(a_count),  32'd0);
      check_eq("rst_afull",  32'(a_af),     32'd0);
      check_eq("rst_aempty", 32'(a_ae),     32'd1);
      check_eq("rst_b_mvalid", 32'(b_mvalid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_tready", 32'(a_tready), 32'd1);

      // Fill 0x01..0x04 with the consumer stalled
      for (int i = 1; i <= 4; i++) begin
         a_tvalid = 1'b1; a_tdata = 8'(i); a_tlast = (i == 4);
         @(negedge clk);
      end
      check_eq("fill_count",  32'(a_count),  32'd4);
      check_eq("fill_tready", 32'(a_tready), 32'd0);
      check_eq("fill_afull",  32'(a_af),     32'd1);
      check_eq("fill_mdata",  32'(a_mdata),  32'h01);
      a_tdata = 8'h55;   // refused at full
      @(negedge clk);
      check_eq("full_hold_count", 32'(a_count), 32'd4);
      a_tvalid = 1'b0;
      a_mready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check_eq("drain_mvalid", 32'(a_mvalid), 32'd1);
         check_eq("drain_data",   32'({a_mlast, a_mdata}), 32'({(i == 4), 8'(i)}));
         @(negedge clk);
      end
      check_eq("drain_count",  32'(a_count),  32'd0);
      check_eq("drain_aempty", 32'(a_ae),     32'd1);
      check_eq("drain_mvalid_end", 32'(a_mvalid), 32'd0);

      // Streaming, then random backpressure; each followed by a drain
      a_mready = 1'b0;
      run_a(100, 100, 100);
      run_a(8, 0, 100);
      run_a(20000, 50, 50);
      run_a(12, 0, 100);

      // Packet hold on B (DEPTH=3): nothing visible until tlast is stored
      b_mready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("pkt_hold_mvalid", 32'(b_mvalid), 32'd0);
         b_tvalid = 1'b1; b_tdata = 8'(8'h10 + i); b_tlast = (i == 3);
      end
      @(negedge clk);
      b_tvalid = 1'b0; b_tlast = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_eq("pkt_mvalid", 32'(b_mvalid), 32'd1);
         check_eq("pkt_data",   32'({b_mlast, b_mdata}), 32'({(i == 3), 8'(8'h10 + i)}));
         @(negedge clk);
      end
      check_eq("pkt_empty", 32'(b_mvalid), 32'd0);

      // Oversize packet on C (DEPTH=2): 6 beats, tlast on the 6th
      for (int i = 0; i < 4; i++) begin
         c_tvalid = 1'b1; c_tdata = 8'(8'h20 + i); c_tlast = 1'b0;
         @(negedge clk);
         if (i < 3) check_eq("ovr_hold_mvalid", 32'(c_mvalid), 32'd0);
      end
      check_eq("ovr_full_count",  32'(c_count),  32'd4);
      check_eq("ovr_full_mvalid", 32'(c_mvalid), 32'd1);
      check_eq("ovr_full_tready", 32'(c_tready), 32'd0);
      pushed = 4; pops = 0; c_exp = 8'h20;
      c_mready = 1'b1;
      for (int cyc = 0; cyc < 30 && pops < 6; cyc++) begin
         c_tvalid = (pushed < 6);
         c_tdata  = 8'(8'h20 + pushed);
         c_tlast  = (pushed == 5);
         if (c_mvalid) begin
            check_eq("ovr_data", 32'({c_mlast, c_mdata}), 32'({(c_exp == 8'h25), c_exp}));
            c_exp = c_exp + 8'd1;
            pops++;
         end
         if (c_tvalid && c_tready) pushed++;
         @(negedge clk);
      end
      c_tvalid = 1'b0;
      check_eq("ovr_pops", 32'(pops), 32'd6);
      check_eq("ovr_count_end", 32'(c_count), 32'd0);

      // Mid-operation reset on A
      a_mready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_tvalid = 1'b1; a_tdata = 8'(8'hA1 + i); a_tlast = 1'b0;
         @(negedge clk);
      end
      a_tvalid = 1'b0;
      check_eq("mid_fill_count", 32'(a_count), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_count",  32'(a_count),  32'd0);
      check_eq("mid_rst_mvalid", 32'(a_mvalid), 32'd0);
      check_eq("mid_rst_tready", 32'(a_tready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_post_tready", 32'(a_tready), 32'd1);
      a_tvalid = 1'b1; a_tdata = 8'hB1; a_tlast = 1'b1;
      @(negedge clk);
      a_tvalid = 1'b0;
      check_eq("mid_first_mvalid", 32'(a_mvalid), 32'd1);
      check_eq("mid_first_data",   32'({a_mlast, a_mdata}), 32'h1B1);
      check_eq("mid_first_count",  32'(a_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
